vga_anim_sprite_core: RTL



---
 rtl/vga_anim_sprite_core.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vga_anim_sprite_core.sv
// ---------------------------------------------------------------------------
// vga_anim_sprite_core
//
// Multi-sprite overlay on the VGA pixel stream. There are NUM_SPR independent
// square sprites. Each one has its own 2-bit-per-pixel RAM, which holds
// 2**FRAMES_LOG2 animation frames. Each sprite also has a position, mirror
// flags, a 3-entry palette and an animation ticker that advances on
// video-frame boundaries. Colour index 0 is transparent. Among the opaque
// sprites covering a pixel, the lowest-numbered one wins. The blended pixel
// leaves on so_rgb exactly two clocks after (x, y, si_rgb) enters.
//
// Ports:
//   clk      in   1   system clock
//   reset    in   1   asynchronous, active-high reset
//   x, y     in  11   current pixel column / row from the frame counter
//   cs       in   1   video-slot chip select
//   write    in   1   write strobe (reads are not supported)
//   addr     in  14   slot word address
//                     [13]=0 : pixel RAM, word {sprite, frame, row, col}
//                     [13]=1 : registers, [7:4] sprite, [3:0] register
//   wr_data  in  32   write data
//   si_rgb   in  CD   upstream pixel
//   so_rgb   out CD   downstream pixel (registered)
// ---------------------------------------------------------------------------
module vga_anim_sprite_core #(
    parameter int CD          = 12,
    parameter int NUM_SPR     = 4,
    parameter int SIZE_LOG2   = 4,
    parameter int FRAMES_LOG2 = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [10:0]   x,
    input  logic [10:0]   y,
    input  logic          cs,
    input  logic          write,
    input  logic [13:0]   addr,
    input  logic [31:0]   wr_data,
    input  logic [CD-1:0] si_rgb,
    output logic [CD-1:0] so_rgb
);

    localparam int SPR_AW    = FRAMES_LOG2 + 2 * SIZE_LOG2;
    localparam int SPR_WORDS = 1 << SPR_AW;
    localparam int SIZE      = 1 << SIZE_LOG2;

    // Configuration sanity check at elaboration time.
    generate
        if ((NUM_SPR < 1) || (NUM_SPR > 15) || (NUM_SPR * SPR_WORDS > 8192)) begin : g_param_err
            $error("vga_anim_sprite_core: NUM_SPR must be 1..15 and NUM_SPR*2**(FRAMES_LOG2+2*SIZE_LOG2) <= 8192");
        end
    endgenerate

    // Palette lookup. Index 0 is transparent and never reaches this function
    // with a winner, so it maps to zero.
    function automatic logic [CD-1:0] pal_sel(
        input logic [1:0]    idx,
        input logic [CD-1:0] p1,
        input logic [CD-1:0] p2,
        input logic [CD-1:0] p3
    );
        logic [CD-1:0] res;
        case (idx)
            2'd1:    res = p1;
            2'd2:    res = p2;
            2'd3:    res = p3;
            default: res = {CD{1'b0}};
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic              wr_en_s;
    logic              ram_we_s;
    logic              reg_we_s;
    logic [3:0]        reg_spr_s;
    logic [3:0]        reg_sel_s;
    logic [12:0]       ram_spr_s;
    logic [SPR_AW-1:0] ram_waddr_s;
    logic              unused_wr_data_s;

    assign wr_en_s     = cs & write;
    assign ram_we_s    = wr_en_s & ~addr[13];
    assign reg_we_s    = wr_en_s & addr[13];
    assign reg_spr_s   = addr[7:4];
    assign reg_sel_s   = addr[3:0];
    // The sprite field sits above the per-sprite word index. A field of
    // NUM_SPR or more matches no sprite, so the write is dropped.
    assign ram_spr_s   = addr[12:0] >> SPR_AW;
    assign ram_waddr_s = addr[SPR_AW-1:0];
    assign unused_wr_data_s = ^wr_data;

    // ------------------------------------------------------------------
    // Per-sprite register file
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0]     en_r;
    logic [NUM_SPR-1:0]     hmir_r;
    logic [NUM_SPR-1:0]     vmir_r;
    logic [NUM_SPR-1:0]     run_r;
    logic [10:0]            x0_r    [NUM_SPR];
    logic [10:0]            y0_r    [NUM_SPR];
    logic [7:0]             rate_r  [NUM_SPR];
    logic [7:0]             cnt_r   [NUM_SPR];
    logic [FRAMES_LOG2-1:0] frame_r [NUM_SPR];
    logic [CD-1:0]          pal_r   [NUM_SPR][3];
    logic                   bypass_r;

    // Control, position, palette and bypass register writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            en_r     <= '0;
            hmir_r   <= '0;
            vmir_r   <= '0;
            bypass_r <= 1'b0;
            for (int i = 0; i < NUM_SPR; i++) begin
                x0_r[i] <= 11'd0;
                y0_r[i] <= 11'd0;
                for (int j = 0; j < 3; j++) begin
                    pal_r[i][j] <= {CD{1'b0}};
                end
            end
        end else begin
            if (reg_we_s && (reg_spr_s == 4'd15) && (reg_sel_s == 4'd0)) begin
                bypass_r <= wr_data[0];
            end
            for (int i = 0; i < NUM_SPR; i++) begin
                if (reg_we_s && (reg_spr_s == 4'(i))) begin
                    case (reg_sel_s)
                        4'd0: begin
                            en_r[i]   <= wr_data[0];
                            hmir_r[i] <= wr_data[1];
                            vmir_r[i] <= wr_data[2];
                        end
                        4'd1:    x0_r[i]     <= wr_data[10:0];
                        4'd2:    y0_r[i]     <= wr_data[10:0];
                        4'd5:    pal_r[i][0] <= wr_data[CD-1:0];
                        4'd6:    pal_r[i][1] <= wr_data[CD-1:0];
                        4'd7:    pal_r[i][2] <= wr_data[CD-1:0];
                        default: ;
                    endcase
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame tick: one pulse when the scan returns to the origin
    // ------------------------------------------------------------------
    logic at_origin_s;
    logic prev_origin_r;
    logic tick_r;

    assign at_origin_s = (x == 11'd0) && (y == 11'd0);

    // Edge-detect arrival at (0,0) so a stalled counter cannot re-trigger.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_origin_r <= 1'b0;
            tick_r        <= 1'b0;
        end else begin
            prev_origin_r <= at_origin_s;
            tick_r        <= at_origin_s & ~prev_origin_r;
        end
    end

    // Animation: an anim-register write loads rate/run/frame and clears the
    // tick counter. This has priority over a coincident frame tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_r <= '0;
            for (int i = 0; i < NUM_SPR; i++) begin
                rate_r[i]  <= 8'd0;
                cnt_r[i]   <= 8'd0;
                frame_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPR; i++) begin
                if (reg_we_s && (reg_spr_s == 4'(i)) && (reg_sel_s == 4'd3)) begin
                    rate_r[i]  <= wr_data[7:0];
                    run_r[i]   <= wr_data[8];
                    cnt_r[i]   <= 8'd0;
                    frame_r[i] <= wr_data[FRAMES_LOG2+15:16];
                end else if (tick_r && run_r[i] && (rate_r[i] != 8'd0)) begin
                    if (cnt_r[i] == (rate_r[i] - 8'd1)) begin
                        cnt_r[i]   <= 8'd0;
                        frame_r[i] <= frame_r[i] + FRAMES_LOG2'(1);
                    end else begin
                        cnt_r[i] <= cnt_r[i] + 8'd1;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: hit test, mirroring and synchronous pixel RAM read
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0] hit_q_s;
    logic [1:0]         idx_q_s [NUM_SPR];

    for (genvar g = 0; g < NUM_SPR; g++) begin : g_spr
        logic [1:0]           mem [SPR_WORDS];
        logic [10:0]          dx_s;
        logic [10:0]          dy_s;
        logic                 hit_s;
        logic [SIZE_LOG2-1:0] col_s;
        logic [SIZE_LOG2-1:0] row_s;
        logic [SPR_AW-1:0]    rd_addr_s;
        logic                 hit_r;
        logic [1:0]           idx_r;

        // Unsigned 11-bit wrap: pixels left of or above the origin give a
        // large dx/dy and fall outside the sprite.
        assign dx_s      = x - x0_r[g];
        assign dy_s      = y - y0_r[g];
        assign hit_s     = en_r[g] && (dx_s < 11'(SIZE)) && (dy_s < 11'(SIZE));
        assign col_s     = hmir_r[g] ? ~dx_s[SIZE_LOG2-1:0] : dx_s[SIZE_LOG2-1:0];
        assign row_s     = vmir_r[g] ? ~dy_s[SIZE_LOG2-1:0] : dy_s[SIZE_LOG2-1:0];
        assign rd_addr_s = {frame_r[g], row_s, col_s};

        // Pixel RAM write port. The contents are intentionally not reset.
        always_ff @(posedge clk) begin
            if (ram_we_s && (ram_spr_s == 13'(g))) begin
                mem[ram_waddr_s] <= wr_data[1:0];
            end
        end

        // Read port plus the matching hit flag. A same-cycle write returns
        // the old word.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                hit_r <= 1'b0;
                idx_r <= 2'd0;
            end else begin
                hit_r <= hit_s;
                idx_r <= mem[rd_addr_s];
            end
        end

        assign hit_q_s[g] = hit_r;
        assign idx_q_s[g] = idx_r;
    end

    // ------------------------------------------------------------------
    // Stage 2: priority blend and output register
    // ------------------------------------------------------------------
    logic [CD-1:0] si_d1_r;
    logic [CD-1:0] pix_s;
    logic          found_s;

    // Upstream pixel delay that matches the RAM read stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            si_d1_r <= {CD{1'b0}};
        end else begin
            si_d1_r <= si_rgb;
        end
    end

    // Lowest-numbered opaque sprite wins. The palette is read live, so a
    // palette change is visible on the next pixel.
    always_comb begin
        found_s = 1'b0;
        pix_s   = si_d1_r;
        for (int i = 0; i < NUM_SPR; i++) begin
            if (!found_s && hit_q_s[i] && (idx_q_s[i] != 2'd0)) begin
                found_s = 1'b1;
                pix_s   = pal_sel(idx_q_s[i], pal_r[i][0], pal_r[i][1], pal_r[i][2]);
            end else begin
                found_s = found_s;
            end
        end
    end

    // Output register. Bypass forwards the delayed upstream pixel untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            so_rgb <= {CD{1'b0}};
        end else begin
            so_rgb <= bypass_r ? si_d1_r : pix_s;
        end
    end

endmodule
